// File: rtl/instr_encoder_loader.sv
// Packs symbolic instruction fields into 16-bit words and streams them into instruction memory,
// holding the CPU during the load and flagging malformed or excess instructions.
module instr_encoder_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [2:0]  in_rx,
  input  logic [2:0]  in_ry,
  input  logic [10:0] in_imm,
  input  logic        in_last,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_wr,
  input  logic        mem_ack,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] word_count
);

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERROR} state_t;

  state_t      state;
  logic        last_q;
  logic [15:0] enc_word;
  logic        op_legal;
  logic        imm_bad;

  always_comb begin
    enc_word = 16'h0000;
    op_legal = 1'b0;
    imm_bad  = 1'b0;
    case (in_op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
      5'b00101, 5'b01000, 5'b01001, 5'b01010, 5'b01100: begin
        enc_word = {5'b00000, in_ry, in_rx, in_op};
        op_legal = 1'b1;
      end
      5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110: begin
        enc_word = {in_imm[7:0], in_rx, in_op};
        op_legal = 1'b1;
        // imm8 is signed: the unused upper bits must be a sign extension of bit 7
        imm_bad  = (in_imm[10:8] != {3{in_imm[7]}});
      end
      5'b11000, 5'b11001, 5'b11010, 5'b11100: begin
        enc_word = {in_imm, in_op};
        op_legal = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_q     <= 1'b0;
      in_ready   <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= 16'h0000;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      word_count <= 16'h0000;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= LOAD;
            in_ready   <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            word_count <= 16'h0000;
            mem_addr   <= BASE_ADDR;
          end
        end
        LOAD: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (word_count == DEPTH_W || !op_legal || imm_bad) begin
              state    <= ERROR;
              cpu_hold <= 1'b0;
              err      <= 1'b1;
              if (word_count == DEPTH_W) err_code <= 2'b11;
              else if (!op_legal)        err_code <= 2'b01;
              else                       err_code <= 2'b10;
            end else begin
              state     <= WRITE;
              mem_wdata <= enc_word;
              mem_wr    <= 1'b1;
              last_q    <= in_last;
            end
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_wr     <= 1'b0;
            word_count <= word_count + 16'd1;
            mem_addr   <= mem_addr + 16'd2;
            if (last_q) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader (DEPTH=4 so overflow is reachable quickly).
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, in_last;
  logic [4:0]  in_op;
  logic [2:0]  in_rx, in_ry;
  logic [10:0] in_imm;
  logic [15:0] mem_addr, mem_wdata, word_count;
  logic        mem_wr, mem_ack, cpu_hold, done, err;
  logic [1:0]  err_code;

  int checks = 0;
  int failures = 0;
  int writes = 0;
  int ack_delay = 0;
  logic [15:0] exp_addr;
  logic [31:0] sb[$];

  instr_encoder_loader #(.BASE_ADDR(16'h0000), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rx(in_rx), .in_ry(in_ry), .in_imm(in_imm), .in_last(in_last),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_ack(mem_ack),
    .cpu_hold(cpu_hold), .done(done), .err(err), .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: acks after ack_delay stalled cycles, checks stability and scoreboard order.
  initial begin
    int stall;
    logic [15:0] hold_addr, hold_data;
    logic [31:0] e;
    stall = 0;
    hold_addr = '0;
    hold_data = '0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !mem_wr) begin
        stall = 0;
        mem_ack = 1'b0;
      end else if (stall < ack_delay) begin
        if (stall == 0) begin
          hold_addr = mem_addr;
          hold_data = mem_wdata;
        end else begin
          chk("stall_addr", mem_addr, hold_addr);
          chk("stall_data", mem_wdata, hold_data);
          chk("stall_ready", in_ready, 0);
        end
        stall++;
        mem_ack = 1'b0;
      end else begin
        mem_ack = 1'b1;
        stall = 0;
        writes++;
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("wr_addr", mem_addr, e[31:16]);
          chk("wr_data", mem_wdata, e[15:0]);
        end
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = 16'h0000;
    chk("load_ready", in_ready, 1);
    chk("load_hold", cpu_hold, 1);
  endtask

  task automatic send(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry,
                      input logic [10:0] imm, input logic last, input bit ok, input logic [15:0] word);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", in_ready, 1);
    in_op = op; in_rx = rx; in_ry = ry; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    if (ok) begin
      sb.push_back({exp_addr, word});
      exp_addr = exp_addr + 16'd2;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk(ok ? "latency_wr" : "err_no_wr", mem_wr, ok);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || err) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("end_timeout", done || err, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", in_ready, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_wdata", mem_wdata, 16'h0000);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_count", word_count, 0);
  endtask

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rx = '0; in_ry = '0; in_imm = '0; exp_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reset_vals();

    // two-word program
    do_start();
    send(5'b00001, 3'd1, 3'd2, 11'h000, 1'b0, 1, 16'h0221);
    send(5'b10000, 3'd3, 3'd0, 11'h05A, 1'b1, 1, 16'h5A70);
    wait_end();
    chk("t1_done", done, 1);
    chk("t1_count", word_count, 2);
    chk("t1_hold", cpu_hold, 0);
    chk("t1_addr", mem_addr, 16'h0004);

    // single jump, restart from DONE
    do_start();
    chk("restart_done_clr", done, 0);
    send(5'b11000, 3'd5, 3'd6, 11'h004, 1'b1, 1, 16'h0098);
    wait_end();
    chk("t2_done", done, 1);
    chk("t2_count", word_count, 1);
    chk("t2_hold", cpu_hold, 0);

    // slow memory ack
    ack_delay = 5;
    do_start();
    send(5'b00001, 3'd7, 3'd7, 11'h000, 1'b0, 1, 16'h07E1);
    ack_delay = 0;
    send(5'b00010, 3'd2, 3'd5, 11'h000, 1'b1, 1, 16'h0542);
    wait_end();
    chk("t3_count", word_count, 2);

    // illegal opcode, bad immediate, legal negative immediate
    do_start();
    w0 = writes;
    send(5'b00110, 3'd0, 3'd0, 11'h000, 1'b0, 0, 16'h0000);
    chk("ill_err", err, 1);
    chk("ill_code", err_code, 2'b01);
    chk("ill_hold", cpu_hold, 0);
    chk("ill_ready", in_ready, 0);
    do_start();
    chk("start_clr_err", err, 0);
    chk("start_clr_code", err_code, 0);
    send(5'b10001, 3'd1, 3'd0, 11'h100, 1'b0, 0, 16'h0000);
    chk("imm_err", err, 1);
    chk("imm_code", err_code, 2'b10);
    repeat (3) @(negedge clk);
    chk("err_no_writes", writes, w0);
    do_start();
    send(5'b10010, 3'd4, 3'd0, 11'h7F0, 1'b1, 1, 16'hF092);
    wait_end();
    chk("neg_imm_done", done, 1);

    // overflow at DEPTH=4
    do_start();
    for (int i = 0; i < 4; i++)
      send(5'b11100, 3'd0, 3'd0, 11'(i), 1'b0, 1, 16'((i << 5) | 16'h001C));
    w0 = writes;
    send(5'b00000, 3'd1, 3'd1, 11'h000, 1'b0, 0, 16'h0000);
    chk("ovf_err", err, 1);
    chk("ovf_code", err_code, 2'b11);
    chk("ovf_count", word_count, 4);
    repeat (3) @(negedge clk);
    chk("ovf_no_write", writes, w0);

    // reset during a pending write
    ack_delay = 100;
    do_start();
    send(5'b00100, 3'd1, 3'd1, 11'h000, 1'b0, 1, 16'h0124);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    ack_delay = 0;
    chk_reset_vals();

    // start and in_valid together in IDLE: only start acts
    in_op = 5'b00001; in_rx = 3'd1; in_ry = 3'd1; in_last = 1'b1;
    start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk("idle_start_ready", in_ready, 1);
    chk("idle_start_nowr", mem_wr, 0);
    chk("idle_start_count", word_count, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
